isi_fir_channel: RTL and testbench
==================================

Name: isi_fir_channel

Overview:
- Parametrised ISI channel model: convolves a signed PAM symbol stream with a programmable pulse response of NUM_TAPS signed fixed-point coefficients.
- Next generation of the fixed 2-tap channel. Adds run-time coefficient loading, full-precision accumulation, rounding, saturation and a 2-stage pipeline.
- Sits between the PAM-4 symbol mapper and the receiver/equaliser in the SERDES simulation chain.

Parameters:
- NUM_TAPS, 4: pulse-response length in UI; must be ≥1.
- SIGNAL_RESOLUTION, 8: width of signed input and output samples.
- COEF_WIDTH, 8: width of signed coefficients.
- COEF_FRAC_BITS, 6: fractional bits of a coefficient; 1.0 = 2^COEF_FRAC_BITS = 64.
- ACC_WIDTH, SIGNAL_RESOLUTION+COEF_WIDTH+$clog2(NUM_TAPS)+1: internal accumulator width, derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  max(1,$clog2(NUM_TAPS))  tap index; 0 = main cursor.
- coef_wr_data  in  COEF_WIDTH  signed coefficient value.
- signal_in  in  SIGNAL_RESOLUTION  signed input symbol.
- signal_in_valid  in  1  input sample qualifier.
- signal_out  out  SIGNAL_RESOLUTION  signed channel output.
- signal_out_valid  out  1  output qualifier.
- sat_flag  out  1  signal_out was clipped; meaningful only when signal_out_valid=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - signal_out=0, signal_out_valid=0, sat_flag=0.
  - Delay line and product stage cleared, including its valid bit.
  - coef[0]=2^COEF_FRAC_BITS; all other coefficients 0. The post-reset channel is therefore the identity.
  - Reset overrides everything else in the same cycle: in-flight samples are dropped and any coefficient write is ignored.
- Delay line:
  - x[0..NUM_TAPS-2] holds the previous accepted samples, x[0] newest.
  - It shifts only on cycles with signal_in_valid=1. Gaps in valid hold its state, so the model counts in UI, not clocks.
- Stage 1 (edge where signal_in_valid=1):
  - Register p[0]=signal_in*coef[0] and p[k]=x[k-1]*coef[k] for k≥1. Products are full precision, signed.
  - Shift signal_in into x[0] and set v1=1.
  - If signal_in_valid=0, set v1=0 and leave the p registers don't-care.
- Stage 2 (every edge):
  - sum = Σp[k], sign-extended to ACC_WIDTH; no overflow is possible.
  - Round half up: r = (sum + 2^(COEF_FRAC_BITS-1)) >>> COEF_FRAC_BITS, arithmetic shift. If COEF_FRAC_BITS=0, r=sum.
  - Saturate r to [-2^(SIGNAL_RESOLUTION-1), 2^(SIGNAL_RESOLUTION-1)-1].
  - Register signal_out=saturated r, sat_flag=(r outside range), signal_out_valid=v1.
  - signal_out and sat_flag hold their values when v1=0.
- Latency: signal_in_valid=1 sampled at edge N gives signal_out_valid=1 after edge N+1. Fixed at 2 cycles. Throughput is 1 sample/clk. No backpressure.
- Coefficient write:
  - On an edge with coef_wr_en=1 and coef_wr_addr<NUM_TAPS, coef[addr]=coef_wr_data.
  - An out-of-range address is ignored.
  - The new value is used by any stage-1 product computed on a later edge.
  - Write and valid in the same cycle: that sample uses the old coefficient.
- Input magnitude: symbols use SYMBOL_SEPERATION mapping, e.g. ±28, ±84 for 56. The block places no restriction; saturation handles overflow.

Test Plan:
- Identity after reset: rst 2 cycles, then stream 40,-20,100 with valid=1 → outputs 40,-20,100, each 2 cycles after its input, sat_flag=0.
- Impulse response: write coef=[64,32,-16,8], send 64 then three 0s → outputs 64,32,-16,8.
- Saturation: coef=[64,64,64,64], send 100 ×4 → outputs 100,127,127,127 with sat_flag 0,1,1,1. Repeat with -100 ×4 → -100,-128,-128,-128.
- Rounding: coef=[32,0,0,0], inputs 3,-3,1,-1 → outputs 2,-1,1,0.
- Valid gaps and write timing: coef=[64,32,0,0], send 40, idle 5 cycles, send 0 → second output 20 (delay line held). Then write coef[1]=0 in the same cycle as input 10 → that output uses coef[1]=32. The next zero input yields 0.
- Reset mid-stream: with 3 samples in flight assert rst 1 cycle → signal_out_valid=0 for the next 2 cycles. Coefficients return to identity. The next input 50 outputs 50, with no residue from earlier samples.

Source files
------------

// File: rtl/isi_fir_channel.sv
// isi_fir_channel
//   ISI channel model. A signed PAM symbol stream is convolved with a
//   programmable NUM_TAPS-tap pulse response of signed fixed-point
//   coefficients. The result is rounded half-up, saturated and registered.
//   Latency is fixed at 2 cycles and throughput is 1 sample per clock.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset; coefficients return to identity
//   coef_wr_en       coefficient write strobe
//   coef_wr_addr     tap index to write; 0 is the main cursor
//   coef_wr_data     signed coefficient value
//   signal_in        signed input symbol
//   signal_in_valid  input sample qualifier; the delay line shifts only when it is set
//   signal_out       signed, saturated channel output
//   signal_out_valid output qualifier
//   sat_flag         signal_out was clipped; meaningful only with signal_out_valid
module isi_fir_channel #(
  parameter int NUM_TAPS          = 4,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int COEF_WIDTH        = 8,
  parameter int COEF_FRAC_BITS    = 6,
  parameter int ACC_WIDTH         = SIGNAL_RESOLUTION + COEF_WIDTH + $clog2(NUM_TAPS) + 1,
  localparam int ADDR_WIDTH       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                coef_wr_en,
  input  logic [ADDR_WIDTH-1:0]               coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]        coef_wr_data,
  input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                                signal_in_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid,
  output logic                                sat_flag
);

  localparam int PROD_WIDTH = SIGNAL_RESOLUTION + COEF_WIDTH;
  // At least one delay-line entry is kept so the array is never zero-sized.
  localparam int X_LEN      = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;

  localparam logic [ADDR_WIDTH:0]              NUM_TAPS_L = NUM_TAPS;
  localparam logic signed [COEF_WIDTH-1:0]     COEF_ONE   = COEF_WIDTH'(1 << COEF_FRAC_BITS);
  localparam logic signed [ACC_WIDTH-1:0]      OUT_MAX    = ACC_WIDTH'((1 << (SIGNAL_RESOLUTION - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0]      OUT_MIN    = -ACC_WIDTH'(1 << (SIGNAL_RESOLUTION - 1));

  logic signed [COEF_WIDTH-1:0]        coef   [NUM_TAPS];
  logic signed [SIGNAL_RESOLUTION-1:0] x      [X_LEN];
  logic signed [SIGNAL_RESOLUTION-1:0] tap_in [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0]        p      [NUM_TAPS];
  logic                                v1;

  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] clipped;
  logic                        clip;

  // Tap k sees the current sample for k=0 and the delay line otherwise.
  always_comb begin
    tap_in[0] = signal_in;
    for (int unsigned k = 1; k < NUM_TAPS; k++) begin
      tap_in[k] = x[k-1];
    end
  end

  // Coefficient store, delay line and product stage.
  // The product uses the coefficient value held before this edge, so a
  // write coinciding with a valid sample only affects later samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        coef[k] <= (k == 0) ? COEF_ONE : '0;
        p[k]    <= '0;
      end
      for (int unsigned k = 0; k < X_LEN; k++) begin
        x[k] <= '0;
      end
      v1 <= 1'b0;
    end else begin
      if (coef_wr_en && ({1'b0, coef_wr_addr} < NUM_TAPS_L)) begin
        coef[coef_wr_addr] <= coef_wr_data;
      end
      v1 <= signal_in_valid;
      if (signal_in_valid) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          p[k] <= PROD_WIDTH'(tap_in[k]) * PROD_WIDTH'(coef[k]);
        end
        x[0] <= signal_in;
        for (int unsigned k = 1; k < X_LEN; k++) begin
          x[k] <= x[k-1];
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      sum = sum + ACC_WIDTH'(p[k]);
    end
  end

  // Round half up with an arithmetic shift; the accumulator carries one
  // spare bit, so adding the half-LSB cannot overflow.
  generate
    if (COEF_FRAC_BITS > 0) begin : g_round
      localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1 << (COEF_FRAC_BITS - 1));
      always_comb rounded = (sum + HALF) >>> COEF_FRAC_BITS;
    end else begin : g_no_round
      always_comb rounded = sum;
    end
  endgenerate

  always_comb begin
    clipped = rounded;
    clip    = 1'b0;
    if (rounded > OUT_MAX) begin
      clipped = OUT_MAX;
      clip    = 1'b1;
    end else if (rounded < OUT_MIN) begin
      clipped = OUT_MIN;
      clip    = 1'b1;
    end
  end

  // Output stage; data and flag hold while no sample is in stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      signal_out       <= '0;
      signal_out_valid <= 1'b0;
      sat_flag         <= 1'b0;
    end else begin
      signal_out_valid <= v1;
      if (v1) begin
        signal_out <= clipped[SIGNAL_RESOLUTION-1:0];
        sat_flag   <= clip;
      end
    end
  end

endmodule

// File: tb/tb_isi_fir_channel.sv
module tb_isi_fir_channel;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              coef_wr_en = 1'b0;
  logic [1:0]        coef_wr_addr = '0;
  logic signed [7:0] coef_wr_data = '0;
  logic signed [7:0] signal_in = '0;
  logic              signal_in_valid = 1'b0;
  logic signed [7:0] signal_out;
  logic              signal_out_valid;
  logic              sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectation for the sample accepted at the previous edge.
  logic              pend_v = 1'b0;
  logic signed [7:0] pend_out = '0;
  logic              pend_sat = 1'b0;

  isi_fir_channel #(
    .NUM_TAPS(4),
    .SIGNAL_RESOLUTION(8),
    .COEF_WIDTH(8),
    .COEF_FRAC_BITS(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .signal_in(signal_in),
    .signal_in_valid(signal_in_valid),
    .signal_out(signal_out),
    .signal_out_valid(signal_out_valid),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive the input, then check the output of the sample
  // accepted one edge earlier (2-cycle latency overall).
  task automatic step(input string tag, input logic v, input int d,
                      input int eo, input logic es);
    signal_in_valid = v;
    signal_in       = 8'(d);
    @(posedge clk);
    #1;
    if (rst) begin
      check({tag, ".rst_valid"}, int'(signal_out_valid), 0);
      check({tag, ".rst_out"},   int'(signal_out), 0);
      check({tag, ".rst_sat"},   int'(sat_flag), 0);
      pend_v = 1'b0;
    end else begin
      check({tag, ".valid"}, int'(signal_out_valid), int'(pend_v));
      if (pend_v) begin
        check({tag, ".out"}, int'(signal_out), int'(pend_out));
        check({tag, ".sat"}, int'(sat_flag), int'(pend_sat));
      end
      pend_v   = v;
      pend_out = 8'(eo);
      pend_sat = es;
    end
    coef_wr_en = 1'b0;
  endtask

  task automatic wr(input int addr, input int val);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 2'(addr);
    coef_wr_data = 8'(val);
    step("wr", 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    // Identity after reset
    rst = 1'b1;
    step("reset", 1'b0, 0, 0, 1'b0);
    step("reset", 1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    step("ident", 1'b1, 40, 40, 1'b0);
    step("ident", 1'b1, -20, -20, 1'b0);
    step("ident", 1'b1, 100, 100, 1'b0);
    step("ident", 1'b1, 0, 0, 1'b0);
    step("ident", 1'b1, 0, 0, 1'b0);
    step("ident", 1'b1, 0, 0, 1'b0);

    // Impulse response
    wr(0, 64); wr(1, 32); wr(2, -16); wr(3, 8);
    step("imp", 1'b1, 64, 64, 1'b0);
    step("imp", 1'b1, 0, 32, 1'b0);
    step("imp", 1'b1, 0, -16, 1'b0);
    step("imp", 1'b1, 0, 8, 1'b0);

    // Saturation, positive then negative
    wr(0, 64); wr(1, 64); wr(2, 64); wr(3, 64);
    step("satp", 1'b1, 100, 100, 1'b0);
    step("satp", 1'b1, 100, 127, 1'b1);
    step("satp", 1'b1, 100, 127, 1'b1);
    step("satp", 1'b1, 100, 127, 1'b1);
    step("satp_flush", 1'b1, 0, 127, 1'b1);
    step("satp_flush", 1'b1, 0, 127, 1'b1);
    step("satp_flush", 1'b1, 0, 100, 1'b0);
    step("satn", 1'b1, -100, -100, 1'b0);
    step("satn", 1'b1, -100, -128, 1'b1);
    step("satn", 1'b1, -100, -128, 1'b1);
    step("satn", 1'b1, -100, -128, 1'b1);
    step("satn_flush", 1'b1, 0, -128, 1'b1);
    step("satn_flush", 1'b1, 0, -128, 1'b1);
    step("satn_flush", 1'b1, 0, -100, 1'b0);

    // Rounding half up
    wr(0, 32); wr(1, 0); wr(2, 0); wr(3, 0);
    step("round", 1'b1, 3, 2, 1'b0);
    step("round", 1'b1, -3, -1, 1'b0);
    step("round", 1'b1, 1, 1, 1'b0);
    step("round", 1'b1, -1, 0, 1'b0);

    // Valid gaps hold the delay line; write coinciding with a sample
    wr(0, 64); wr(1, 32);
    step("gap", 1'b1, 0, 0, 1'b0);   // -1*32 rounds to 0
    step("gap", 1'b1, 40, 40, 1'b0);
    for (int i = 0; i < 5; i++) step("gap_idle", 1'b0, 0, 0, 1'b0);
    step("gap", 1'b1, 0, 20, 1'b0);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 2'd1;
    coef_wr_data = 8'sd0;
    step("wrsame", 1'b1, 10, 10, 1'b0);
    step("wrsame", 1'b1, 0, 0, 1'b0); // would be 5 if coef[1] still 32
    step("wrsame", 1'b0, 0, 0, 1'b0);
    step("wrsame", 1'b0, 0, 0, 1'b0);

    // Reset mid-stream
    wr(1, 32);
    step("midrst", 1'b1, 11, 11, 1'b0);
    step("midrst", 1'b1, 22, 28, 1'b0);  // 22 + 11*0.5 = 27.5 -> 28
    rst = 1'b1;
    step("midrst", 1'b1, 33, 0, 1'b0);
    rst = 1'b0;
    step("midrst_idle", 1'b0, 0, 0, 1'b0);
    step("midrst_idle", 1'b0, 0, 0, 1'b0);
    step("midrst", 1'b1, 50, 50, 1'b0);
    step("midrst", 1'b1, 0, 0, 1'b0);    // 25 if coef[1] survived reset
    step("midrst", 1'b0, 0, 0, 1'b0);
    step("midrst", 1'b0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
